cla_multiword_sequencer: RTL and testbench
==========================================

# cla_multiword_sequencer

Multi-precision add/subtract sequencer. It computes WORDS×NUMBITS-bit sums by driving one carry_look_ahead_adder instance of width NUMBITS once per cycle, least-significant word first, and chaining the carry through a register. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. The wide operation is time-multiplexed onto a single narrow adder instead of instantiating a wide one.

## Interface
Parameters:
- NUMBITS, 16, width of the internal carry_look_ahead_adder (one word)
- WORDS, 4, number of words per operand (≥2); total width W = NUMBITS*WORDS

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operand request valid
- in_ready  out  1  sequencer can accept an operation
- a  in  W  operand A (unsigned/two's complement)
- b  in  W  operand B
- sub  in  1  1 = A−B, 0 = A+B+cin
- cin  in  1  carry-in for add; ignored when sub=1
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W  result
- cout  out  1  final carry-out of the most-significant word (for sub: 1 = no borrow)
- overflow  out  1  two's-complement overflow of the W-bit result

One clock; reset is asynchronous and active-low.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch a into the A register;
  - latch b, or ~b when sub=1, into the B register;
  - set carry_reg to 1 if sub=1, otherwise to cin;
  - clear the word index k to 0 and the sum register to 0;
  - go to RUN.
- RUN: in_ready=0. The adder receives A word k, B word k and carry_reg. Each cycle:
  - sum word k <= adder result;
  - carry_reg <= adder carryout;
  - k <= k+1.
- On the cycle k==WORDS−1:
  - capture overflow = (A[W−1]==Beff[W−1]) && (adder result MSB != A[W−1]);
  - cout <= adder carryout;
  - go to DONE.
- DONE: out_valid=1. sum, cout and overflow are held stable. On out_ready go to IDLE.
- in_valid is ignored outside IDLE. Operands change freely after acceptance.
- k counts 0..WORDS−1 with no wrap. Its width is clog2(WORDS), minimum 1.
- Reset (at any time, including mid-RUN or in DONE) aborts the operation immediately. Reset values:
  - state=IDLE, k=0, carry_reg=0;
  - sum=0, cout=0, overflow=0, out_valid=0, in_ready=1.
- The adder is purely combinational. All block outputs are registered, or decoded directly from the state register.

## Timing
- Accept at clock edge T0. RUN spans edges T1..TWORDS. out_valid rises after edge TWORDS, so latency is WORDS cycles from the accept edge to out_valid.
- A same-cycle out handshake (out_ready already high) leaves DONE after one cycle. in_ready is high in the following cycle, so throughput is one operation per WORDS+2 cycles. Accept and result never overlap.
- in_ready and out_valid are never high simultaneously.
- The critical path is one NUMBITS-wide CLA plus the carry register. There is no W-wide combinational path except the operand-invert mux.

## Test plan
All cases use NUMBITS=16, WORDS=4, W=64.
- Add, carry crossing a word boundary: a=0x0000_0000_0000_FFFF, b=1, sub=0, cin=0 → sum=0x0000_0000_0001_0000, cout=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- Full wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 → sum=0, cout=1, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cin=0 → sum=0x8000_0000_0000_0000, overflow=1, cout=0.
- Subtract with borrow: a=5, b=7, sub=1, cin=1 (must be ignored) → sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, overflow=0. Then a=7, b=5 → sum=2, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 with new operands → sum, cout and overflow stay stable, in_ready stays 0, and the new request is not accepted until the cycle after out_ready=1.
- Reset mid-RUN: assert rst_n=0 when k=2 → out_valid=0, sum=0 and in_ready=1 immediately (asynchronously). After release, a=3, b=4 gives sum=7 with 4-cycle latency.

Source files
------------

// File: rtl/cla_multiword_sequencer.sv
// Multi-precision add/subtract: one NUMBITS-wide carry-look-ahead adder reused
// once per word, LS word first, with the carry chained through a register.

module carry_look_ahead_adder #(
  parameter int NUMBITS = 16
) (
  input  logic [NUMBITS-1:0] i_a,
  input  logic [NUMBITS-1:0] i_b,
  input  logic               i_cin,
  output logic [NUMBITS-1:0] o_sum,
  output logic               o_cout
);
  localparam int LV = (NUMBITS > 1) ? $clog2(NUMBITS) : 1;

  logic [NUMBITS-1:0] w_g [0:LV];
  logic [NUMBITS-1:0] w_p [0:LV];
  logic [NUMBITS:0]   w_c;

  assign w_g[0] = i_a & i_b;
  assign w_p[0] = i_a ^ i_b;

  // Kogge-Stone prefix tree: level gl combines spans 2^(gl-1) apart
  genvar gl, gi;
  generate
    for (gl = 1; gl <= LV; gl++) begin : g_lvl
      localparam int D = 1 << (gl - 1);
      for (gi = 0; gi < NUMBITS; gi++) begin : g_bit
        if (gi >= D) begin : g_comb
          assign w_g[gl][gi] = w_g[gl-1][gi] | (w_p[gl-1][gi] & w_g[gl-1][gi-D]);
          assign w_p[gl][gi] = w_p[gl-1][gi] & w_p[gl-1][gi-D];
        end else begin : g_pass
          assign w_g[gl][gi] = w_g[gl-1][gi];
          assign w_p[gl][gi] = w_p[gl-1][gi];
        end
      end
    end
    for (gi = 0; gi < NUMBITS; gi++) begin : g_carry
      assign w_c[gi+1] = w_g[LV][gi] | (w_p[LV][gi] & i_cin);
    end
  endgenerate

  assign w_c[0]  = i_cin;
  assign o_sum   = w_p[0] ^ w_c[NUMBITS-1:0];
  assign o_cout  = w_c[NUMBITS];
endmodule

module cla_multiword_sequencer #(
  parameter int NUMBITS = 16,
  parameter int WORDS   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUMBITS*WORDS-1:0] a,
  input  logic [NUMBITS*WORDS-1:0] b,
  input  logic                     sub,
  input  logic                     cin,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUMBITS*WORDS-1:0] sum,
  output logic                     cout,
  output logic                     overflow
);
  localparam int W  = NUMBITS * WORDS;
  localparam int KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            r_state, w_state_next;
  logic [W-1:0]      r_a, r_b, r_sum;
  logic [KW-1:0]     r_k;
  logic              r_carry, r_cout, r_ovf;
  logic [NUMBITS-1:0] w_a_word, w_b_word, w_add_sum;
  logic              w_add_cout, w_last;

  assign w_a_word = r_a[r_k*NUMBITS +: NUMBITS];
  assign w_b_word = r_b[r_k*NUMBITS +: NUMBITS];
  assign w_last   = (r_k == KW'(WORDS - 1));

  carry_look_ahead_adder #(.NUMBITS(NUMBITS)) u_cla (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_state_next = S_RUN;
      S_RUN:   if (w_last)    w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == S_IDLE);
    out_valid = (r_state == S_DONE);
  end

  // r_b holds the effective operand (inverted for subtract)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_a     <= a;
          r_b     <= sub ? ~b : b;
          r_carry <= sub ? 1'b1 : cin;
          r_k     <= '0;
          r_sum   <= '0;
        end
        S_RUN: begin
          r_sum[r_k*NUMBITS +: NUMBITS] <= w_add_sum;
          r_carry <= w_add_cout;
          if (w_last) begin
            r_cout <= w_add_cout;
            r_ovf  <= (r_a[W-1] == r_b[W-1]) && (w_add_sum[NUMBITS-1] != r_a[W-1]);
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_cla_multiword_sequencer.sv
// Scoreboard bench for cla_multiword_sequencer (NUMBITS=16, WORDS=4).

module tb_cla_multiword_sequencer;
  localparam int NB = 16;
  localparam int WD = 4;
  localparam int W  = NB * WD;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  cla_multiword_sequencer #(.NUMBITS(NB), .WORDS(WD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                 input logic isub, input logic icin);
    logic [W-1:0] beff;
    logic [W:0]   full;
    exp_t         e;
    beff = isub ? ~ib : ib;
    full = {1'b0, ia} + {1'b0, beff} + {{W{1'b0}}, (isub ? 1'b1 : icin)};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (ia[W-1] == beff[W-1]) && (full[W-1] != ia[W-1]);
    return e;
  endfunction

  // Drive one request from posedge+1; returns at accept edge + 1
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                      input logic icin, input exp_t e, output logic was_ready);
    a = ia; b = ib; sub = isub; cin = icin; in_valid = 1'b1;
    sb.push_back(e);
    #1 was_ready = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output exp_t got, output exp_t e);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    got.s = sum; got.c = cout; got.o = overflow;
    e = (sb.size() != 0) ? sb.pop_front() : '0;
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (sum !== '0)         begin n_fail++; $display("FAIL reset_sum got %h want 0", sum); end
    n_checks++; if ({cout, overflow} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got %b want 00", {cout, overflow}); end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_arith;
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic [1:0]   tsc [5];
    exp_t         te [5];
    exp_t         got, e;
    int           lat;
    logic         rdy;
    ta[0] = 64'h0000_0000_0000_FFFF; tb[0] = 64'd1; tsc[0] = 2'b00; te[0] = {64'h0000_0000_0001_0000, 1'b0, 1'b0};
    ta[1] = 64'hFFFF_FFFF_FFFF_FFFF; tb[1] = 64'd0; tsc[1] = 2'b01; te[1] = {64'h0, 1'b1, 1'b0};
    ta[2] = 64'h7FFF_FFFF_FFFF_FFFF; tb[2] = 64'd1; tsc[2] = 2'b00; te[2] = {64'h8000_0000_0000_0000, 1'b0, 1'b1};
    ta[3] = 64'd5; tb[3] = 64'd7; tsc[3] = 2'b11; te[3] = {64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    ta[4] = 64'd7; tb[4] = 64'd5; tsc[4] = 2'b10; te[4] = {64'd2, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      send(ta[i], tb[i], tsc[i][1], tsc[i][0], te[i], rdy);
      collect(lat, got, e);
      $display("arith[%0d] a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b lat=%0d",
               i, ta[i], tb[i], tsc[i][1], tsc[i][0], got.s, got.c, got.o, lat);
      n_checks++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL arith_in_ready[%0d] got %b want 1", i, rdy); end
      n_checks++; if (lat != WD)    begin n_fail++; $display("FAIL arith_latency[%0d] got %0d want %0d", i, lat, WD); end
      n_checks++; if (got.s !== e.s) begin n_fail++; $display("FAIL arith_sum[%0d] got %h want %h", i, got.s, e.s); end
      n_checks++; if (got.c !== e.c) begin n_fail++; $display("FAIL arith_cout[%0d] got %b want %b", i, got.c, e.c); end
      n_checks++; if (got.o !== e.o) begin n_fail++; $display("FAIL arith_ovf[%0d] got %b want %b", i, got.o, e.o); end
      @(posedge clk); #1;
      n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL arith_release[%0d] got ov/ir=%b want 01", i, {out_valid, in_ready}); end
    end
  endtask

  task automatic test_backpressure;
    exp_t got, e;
    int   lat;
    logic rdy;
    out_ready = 1'b0;
    send(64'd7, 64'd5, 1'b1, 1'b0, '{s: 64'd2, c: 1'b1, o: 1'b0}, rdy);
    collect(lat, got, e);
    n_checks++; if (got.s !== e.s || got.c !== e.c) begin n_fail++; $display("FAIL bp_result got %h/%b want %h/%b", got.s, got.c, e.s, e.c); end
    a = 64'd3; b = 64'd4; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
    sb.push_back('{s: 64'd7, c: 1'b0, o: 1'b0});
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      $display("bp hold cycle %0d sum=%h cout=%b ovf=%b in_ready=%b out_valid=%b", i, sum, cout, overflow, in_ready, out_valid);
      n_checks++;
      if ({sum, cout, overflow, in_ready, out_valid} !== {64'd2, 1'b1, 1'b0, 1'b0, 1'b1}) begin
        n_fail++; $display("FAIL bp_hold[%0d] got sum=%h c=%b o=%b ir=%b ov=%b want sum=2 c=1 o=0 ir=0 ov=1",
                           i, sum, cout, overflow, in_ready, out_valid);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release got ov/ir=%b want 01", {out_valid, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_accept in_ready got %b want 0", in_ready); end
    collect(lat, got, e);
    $display("bp new op sum=%h cout=%b lat=%0d", got.s, got.c, lat);
    n_checks++; if (lat != WD)     begin n_fail++; $display("FAIL bp_latency got %0d want %0d", lat, WD); end
    n_checks++; if (got.s !== e.s) begin n_fail++; $display("FAIL bp_new_sum got %h want %h", got.s, e.s); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_run;
    exp_t got, e;
    int   lat;
    logic rdy;
    send(64'h0001_0001_0001_0001, 64'd0, 1'b0, 1'b0, '0, rdy);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (in_ready !== 1'b0 || sum === '0) begin n_fail++; $display("FAIL midrun_state got ir=%b sum=%h want ir=0 sum!=0", in_ready, sum); end
    rst_n = 1'b0;
    #1;
    $display("mid-run reset: out_valid=%b in_ready=%b sum=%h", out_valid, in_ready, sum);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL midrun_reset ov/ir got %b want 01", {out_valid, in_ready}); end
    n_checks++; if (sum !== '0) begin n_fail++; $display("FAIL midrun_reset_sum got %h want 0", sum); end
    sb.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send(64'd3, 64'd4, 1'b0, 1'b0, '{s: 64'd7, c: 1'b0, o: 1'b0}, rdy);
    collect(lat, got, e);
    $display("post-reset op sum=%h lat=%0d", got.s, lat);
    n_checks++; if (lat != WD)     begin n_fail++; $display("FAIL postreset_latency got %0d want %0d", lat, WD); end
    n_checks++; if (got.s !== e.s) begin n_fail++; $display("FAIL postreset_sum got %h want %h", got.s, e.s); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    exp_t         got, e;
    int           lat;
    logic         rdy;
    logic [W-1:0] ra, rb;
    logic         rs, rc;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rc, model(ra, rb, rs, rc), rdy);
      collect(lat, got, e);
      $display("b2b[%0d] a=%h b=%h sub=%b cin=%b -> sum=%h cout=%b ovf=%b", i, ra, rb, rs, rc, got.s, got.c, got.o);
      n_checks++; if (rdy !== 1'b1 || lat != WD) begin n_fail++; $display("FAIL b2b_timing[%0d] got rdy=%b lat=%0d want 1/%0d", i, rdy, lat, WD); end
      n_checks++; if (got !== e) begin n_fail++; $display("FAIL b2b_result[%0d] got %h/%b/%b want %h/%b/%b", i, got.s, got.c, got.o, e.s, e.c, e.o); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_arith;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
